// File: rtl/seq_detect_prog.sv
// Programmable serial bit-pattern detector: run-time pattern, length and overlap mode,
// Mealy match output, registered match and a saturating match counter.
module seq_detect_prog #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din,
    input  logic               din_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               y,
    output logic               y_q,
    output logic [CNT_W-1:0]   match_count,
    output logic [LEN_W-1:0]   fill
);

    localparam logic [LEN_W-1:0] LenMax = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    // The oldest history bit can never take part in a compare ({hist, din} is at most
    // MAX_LEN wide once din is appended), so only MAX_LEN-1 bits are kept.
    logic [MAX_LEN-2:0] hist_q;
    logic [LEN_W-1:0]   fill_q;
    logic [LEN_W-1:0]   fill_d;
    logic [LEN_W:0]     fill_p1;
    logic [MAX_LEN-1:0] window;
    logic [LEN_W-1:0]   len_clamped;
    logic               accept;
    logic               bits_eq;
    logic               hit;

    assign fill = fill_q;

    always_comb begin
        window      = {hist_q, din};
        accept      = din_valid & ~cfg_load;
        len_clamped = (cfg_len > LenMax) ? LenMax : cfg_len;
        fill_p1     = {1'b0, fill_q} + (LEN_W + 1)'(1);

        bits_eq = 1'b1;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            if (i < int'(len_q) && window[i] != pat_q[i]) begin
                bits_eq = 1'b0;
            end
        end

        // fill >= len-1 written as fill+1 >= len to avoid underflow at len=0
        hit = accept && (len_q != '0) && (fill_p1 >= {1'b0, len_q}) && bits_eq;
        y   = hit;

        if (hit && !ovl_q) begin
            fill_d = '0;
        end else if (fill_q == LenMax) begin
            fill_d = fill_q;
        end else begin
            fill_d = fill_p1[LEN_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q       <= MAX_LEN'(4'b1101);
            len_q       <= LEN_W'(4);
            ovl_q       <= 1'b1;
            hist_q      <= '0;
            fill_q      <= '0;
            y_q         <= 1'b0;
            match_count <= '0;
        end else begin
            y_q <= y;

            if (cnt_clr) begin
                match_count <= '0;
            end else if (y && match_count != '1) begin
                match_count <= match_count + CNT_W'(1);
            end

            if (cfg_load) begin
                pat_q  <= cfg_pattern;
                len_q  <= len_clamped;
                ovl_q  <= cfg_overlap;
                hist_q <= '0;
                fill_q <= '0;
            end else if (din_valid) begin
                hist_q <= window[MAX_LEN-2:0];
                fill_q <= fill_d;
            end
        end
    end

endmodule
